// File: rtl/ahb_ram_subordinate.sv
// AHB-Lite subordinate backed by a word-addressed RAM, with configurable wait states and ERROR responses.
// Define AHB_RAM_WSTRB_EN to qualify write byte lanes with hwstrb as well as with the size/offset mask.
module ahb_ram_subordinate #(
  parameter int                      AddressWidth = 32,
  parameter int                      DataWidth    = 32,
  parameter int                      Depth        = 1024,
  parameter logic [AddressWidth-1:0] BaseAddress  = '0,
  parameter int                      WaitStates   = 0
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [AddressWidth-1:0]   haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [2:0]                hburst,
  input  logic [DataWidth/8-1:0]    hwstrb,
  input  logic [DataWidth-1:0]      hwdata,
  input  logic                      hready,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [DataWidth-1:0]      hrdata
);

  localparam int BYTES = DataWidth / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_hreadyout;
  logic                   r_hresp;
  logic [IDX_W-1:0]       r_index;
  logic                   r_write;
  logic [BYTES-1:0]       r_mask;
  logic [DataWidth-1:0]   r_mem [Depth];

  logic                   w_accept;
  logic                   w_below;
  logic [AddressWidth-1:0] w_offset;
  logic [AddressWidth-1:0] w_index;
  logic [AddressWidth-1:0] w_align_m;
  logic                   w_err;
  logic [BYTES-1:0]       w_wmask;
  logic                   w_unused;

  // Lanes covered by a transfer of 2**size bytes starting at addr's byte offset in the word.
  function automatic logic [BYTES-1:0] size_mask(input logic [2:0] size,
                                                 input logic [AddressWidth-1:0] addr);
    logic [31:0] m;
    m = (32'd1 << (32'd1 << size)) - 32'd1;
    m = m << (32'(addr) & 32'(BYTES - 1));
    return m[BYTES-1:0];
  endfunction

  // The borrow of the subtraction flags addresses below the RAM window.
  assign {w_below, w_offset} = {1'b0, haddr} - {1'b0, BaseAddress};
  assign w_index   = w_offset >> OFF_W;
  assign w_align_m = (AddressWidth'(1) << hsize) - AddressWidth'(1);
  assign w_err     = w_below | (w_index >= AddressWidth'(Depth)) |
                     (hsize > 3'(OFF_W)) | ((haddr & w_align_m) != '0);
  assign w_accept  = hsel & hready & htrans[1] & r_hreadyout;
  assign w_unused  = ^{hburst, htrans[0], hwstrb};

`ifdef AHB_RAM_WSTRB_EN
  assign w_wmask = r_mask & hwstrb;
`else
  assign w_wmask = r_mask;
`endif

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= S_DONE;
            r_cnt       <= '0;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          // IDLE, DONE and ERR2 all may start the next transfer in the same cycle.
          if (w_accept && w_err) begin
            r_state     <= S_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
          end else if (w_accept && (WaitStates > 0)) begin
            r_state     <= S_WAIT;
            r_cnt       <= 4'(WaitStates);
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b0;
          end else if (w_accept) begin
            r_state     <= S_DONE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (w_accept) begin
      r_index <= w_index[IDX_W-1:0];
      r_write <= hwrite;
      r_mask  <= size_mask(hsize, haddr);
    end
  end

  // The DONE edge commits the write; a reset arriving first leaves the word untouched.
  always_ff @(posedge hclk) begin
    if ((r_state == S_DONE) && r_write && !hreset) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_wmask[b]) r_mem[r_index][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata    = ((r_state == S_DONE) && !r_write) ? r_mem[r_index] : '0;
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;

endmodule

// File: doc/ahb_ram_subordinate.md
# ahb_ram_subordinate

AHB-Lite subordinate (responder) that backs a word-addressed RAM and answers transfers driven by an AHB manager. It is the bus end opposite the Renode-side manager: Renode initiates transfers through the AHB interface, and this block decodes, inserts wait states, and returns OKAY or ERROR responses. It is used as a memory target and as a reference responder in co-simulation benches.

## Interface
- AddressWidth, 32, haddr width
- DataWidth, 32, hwdata/hrdata width; one of 8/16/32/64
- Depth, 1024, RAM depth in DataWidth words
- BaseAddress, 0, byte address of word 0
- WaitStates, 0, hreadyout-low cycles per OKAY data phase (0..15)

- hclk  in  1  bus clock; all state on rising edge
- hreset  in  1  asynchronous, active-high reset
- hsel  in  1  subordinate select
- haddr  in  AddressWidth  byte address (address phase)
- htrans  in  transfer_type_t  IDLE/BUSY/NONSEQ/SEQ
- hwrite  in  transfer_direction_t  1 = write
- hsize  in  transfer_size_t  log2 bytes
- hburst  in  burst_t  ignored
- hwstrb  in  DataWidth/8  byte strobes (used only with the macro)
- hwdata  in  DataWidth  write data (data phase)
- hready  in  1  bus-level ready
- hreadyout  out  1  data phase complete
- hresp  out  response_t  OKAY/ERROR
- hrdata  out  DataWidth  read data

## Operation
- Address phase accepted when hsel & hready & htrans ∈ {NONSEQ, SEQ}; addr, size, direction registered. IDLE/BUSY or hsel=0 → zero-wait OKAY.
- Offset = haddr − BaseAddress; index = offset >> log2(DataWidth/8).
- Error if haddr < BaseAddress, index ≥ Depth, 2**hsize > DataWidth/8, or haddr not aligned to 2**hsize.
- FSM: IDLE → WAIT (WaitStates>0, no error) → DONE; IDLE → DONE (WaitStates=0); IDLE → ERR1 → ERR2 on error. DONE/ERR2 return to IDLE or directly start the next accepted transfer.
- WAIT: hreadyout=0, hresp=OKAY, down-counter from WaitStates to 1.
- DONE: hreadyout=1, hresp=OKAY; read: hrdata = mem[index] (combinational from registered index); write: mem updated at the DONE clock edge from hwdata under the strobe mask.
- ERR1: hreadyout=0, hresp=ERROR; ERR2: hreadyout=1, hresp=ERROR. No RAM write in error.
- hrdata = 0 except in DONE of a read.
- hburst ignored; each beat is independent; SEQ treated as NONSEQ.

## Timing
- Reset (async assert, sync release): hreadyout=1, hresp=OKAY, hrdata=0, FSM IDLE, counter 0. RAM contents are not reset.
- Address phase at cycle N → data phase completes at N+1+WaitStates (OKAY) or N+2 (ERROR).
- Back-to-back: address phase of the next transfer overlaps the completing cycle (hready=1); write then read of same word returns the new data with no hazard.
- New address phase is not sampled while hreadyout=0.
- hreset mid-transfer: transfer abandoned, pending write not committed.

## Configuration
- AHB_RAM_WSTRB_EN defined: write mask = hwstrb sampled in data phase, ANDed with the size/offset mask.
- Not defined: mask = ((1 << 2**hsize) − 1) << (haddr mod DataWidth/8); hwstrb port present but ignored.

## Test plan
- Reset, WaitStates=0: write 32-bit 0xDEADBEEF to 0x10, read 0x10 → hreadyout never low, hresp OKAY, hrdata 0xDEADBEEF at N+1.
- WaitStates=3: read 0x0 → hreadyout low for 3 cycles, high at N+4 with correct data.
- Byte write 0xAA to 0x13 over word 0x11223344 → read of 0x10 returns 0xAA223344.
- Read at BaseAddress + 4·Depth and halfword at 0x1 → ERROR two-cycle response (hreadyout 0 then 1), RAM unchanged.
- Back-to-back write 0x5 / read same address → read returns 0x5 in next cycle.
- Assert hreset during WAIT of a write → outputs at reset values immediately, word unchanged after release.
